// File: rtl/icache_bus_pkg.sv
// rtl/icache_bus_pkg.sv - shared types and AXI constants for the icache refill responder
package icache_bus_pkg;

    // Responder sequencing: latch request, address phase, data beats, hand back line.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RESP = 2'd3
    } refill_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    // Width of one cache line in bits for a given log2(words per line).
    function automatic int line_width(input int offset_width);
        return 32 << offset_width;
    endfunction

endpackage

// File: rtl/refill_line_buf.sv
// rtl/refill_line_buf.sv - word-addressed line assembly buffer
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset (buffer cleared)
//   clr       : zero the whole line this cycle (has priority over we)
//   we/idx/data: write one 32-bit word at word index idx
//   line      : full assembled line, registered
module refill_line_buf
    import icache_bus_pkg::*;
#(
    parameter int offset_width = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clr,
    input  logic                                  we,
    input  logic [offset_width-1:0]               idx,
    input  logic [31:0]                           data,
    output logic [line_width(offset_width)-1:0]   line
);

    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
        end else if (clr) begin
            line <= '0;
        end else if (we) begin
            // Word idx occupies bits 32*idx+31 : 32*idx.
            line[{idx, 5'b0} +: 32] <= data;
        end
    end

endmodule

// File: rtl/icache_refill_responder.sv
// rtl/icache_refill_responder.sv - icache refill / uncached fetch to AXI4 read responder
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   icache_mem_req       : level request, held until mem_icache_dataOK
//   addr_icache_mem      : request physical address
//   icache_mem_SUC       : 1 = single uncached fetch, 0 = full line refill
//   icache_mem_size      : access size for uncached fetch (0=1B,1=2B,2=4B)
//   din_mem_icache       : assembled line, valid with mem_icache_dataOK
//   mem_icache_dataOK    : one-cycle completion pulse
//   ar*                  : AXI read address channel (master side)
//   r*                   : AXI read data channel (master side)
//   bus_err              : sticky error flag, cleared only by reset
module icache_refill_responder
    import icache_bus_pkg::*;
#(
    parameter int         offset_width = 2,
    parameter logic [3:0] axi_id       = 4'd0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 icache_mem_req,
    input  logic [31:0]                          addr_icache_mem,
    input  logic                                 icache_mem_SUC,
    input  logic [1:0]                           icache_mem_size,
    output logic [line_width(offset_width)-1:0]  din_mem_icache,
    output logic                                 mem_icache_dataOK,
    output logic [31:0]                          araddr,
    output logic [7:0]                           arlen,
    output logic [2:0]                           arsize,
    output logic [1:0]                           arburst,
    output logic [3:0]                           arid,
    output logic                                 arvalid,
    input  logic                                 arready,
    input  logic [31:0]                          rdata,
    input  logic [1:0]                           rresp,
    input  logic                                 rlast,
    input  logic [3:0]                           rid,
    input  logic                                 rvalid,
    output logic                                 rready,
    output logic                                 bus_err
);

    localparam logic [7:0] LINE_ARLEN = 8'((1 << offset_width) - 1);

    refill_state_t             state;
    logic [offset_width-1:0]   cnt;
    logic                      last_beat;
    logic                      beat_we;
    logic                      line_clr;
    logic                      rid_unused;

    // Read IDs are not checked: only one transaction is ever outstanding.
    assign rid_unused = ^rid;

    assign arid      = axi_id;
    assign last_beat = (8'(cnt) == arlen);
    assign beat_we   = (state == ST_R) && rvalid;
    // Uncached fetches return one word; the rest of the line must read as zero.
    assign line_clr  = (state == ST_IDLE) && icache_mem_req && icache_mem_SUC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            arvalid           <= 1'b0;
            rready            <= 1'b0;
            mem_icache_dataOK <= 1'b0;
            bus_err           <= 1'b0;
            araddr            <= '0;
            arlen             <= '0;
            arsize            <= '0;
            arburst           <= '0;
        end else begin
            mem_icache_dataOK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (icache_mem_req) begin
                        // AR fields double as the latched request registers, so
                        // they stay stable for the whole address phase.
                        cnt     <= '0;
                        arvalid <= 1'b1;
                        arburst <= AXI_BURST_INCR;
                        state   <= ST_AR;
                        if (icache_mem_SUC) begin
                            araddr <= addr_icache_mem;
                            arlen  <= 8'd0;
                            arsize <= {1'b0, icache_mem_size};
                        end else begin
                            araddr <= {addr_icache_mem[31:2+offset_width],
                                       {(2+offset_width){1'b0}}};
                            arlen  <= LINE_ARLEN;
                            arsize <= AXI_SIZE_4B;
                        end
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        cnt <= cnt + 1'b1;
                        // Protocol problems are flagged but the burst still
                        // completes on our own beat count.
                        if ((rlast != last_beat) || (rresp != AXI_RESP_OKAY)) begin
                            bus_err <= 1'b1;
                        end
                        if (last_beat) begin
                            rready            <= 1'b0;
                            mem_icache_dataOK <= 1'b1;
                            state             <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    refill_line_buf #(
        .offset_width (offset_width)
    ) u_line_buf (
        .clk  (clk),
        .rst  (rst),
        .clr  (line_clr),
        .we   (beat_we),
        .idx  (cnt),
        .data (rdata),
        .line (din_mem_icache)
    );

endmodule

// File: tb/tb_icache_refill_responder.sv
// tb/tb_icache_refill_responder.sv - self-checking bench for icache_refill_responder
module tb_icache_refill_responder;
    import icache_bus_pkg::*;

    localparam int NW = 4;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [31:0]   addr;
    logic          suc;
    logic [1:0]    size;
    logic [LW-1:0] din;
    logic          data_ok;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    arid;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic [3:0]    rid;
    logic          rvalid;
    logic          rready;
    logic          bus_err;

    icache_refill_responder #(.offset_width(2), .axi_id(4'd0)) dut (
        .clk               (clk),
        .rst               (rst),
        .icache_mem_req    (req),
        .addr_icache_mem   (addr),
        .icache_mem_SUC    (suc),
        .icache_mem_size   (size),
        .din_mem_icache    (din),
        .mem_icache_dataOK (data_ok),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arid              (arid),
        .arvalid           (arvalid),
        .arready           (arready),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rid               (rid),
        .rvalid            (rvalid),
        .rready            (rready),
        .bus_err           (bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state, advanced by the stimulus schedule.
    logic        exp_arvalid, exp_rready, exp_err;
    logic [31:0] exp_araddr;
    logic [7:0]  exp_arlen;
    logic [2:0]  exp_arsize;
    logic [31:0] exp_words [NW];
    int          exp_ok_cyc;
    int          last_t0;
    int          ok_seen_cyc;
    int          ok_pulses;
    logic        arv_q;
    logic [31:0] ar_seen_addr;
    logic [7:0]  ar_seen_len;
    logic [2:0]  ar_seen_size;

    function automatic logic [LW-1:0] model_line();
        return {exp_words[3], exp_words[2], exp_words[1], exp_words[0]};
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        check("arvalid", arvalid, exp_arvalid);
        if (exp_arvalid) begin
            check("araddr", araddr, exp_araddr);
            check("arlen", arlen, exp_arlen);
            check("arsize", arsize, exp_arsize);
            check("arburst", arburst, AXI_BURST_INCR);
        end
        check("arid", arid, 4'd0);
        check("rready", rready, exp_rready);
        check("dataOK", data_ok, cyc == exp_ok_cyc);
        check("din", din, model_line());
        check("bus_err", bus_err, exp_err);
        if (data_ok) begin
            ok_seen_cyc = cyc;
            ok_pulses++;
        end
        if (arvalid && !arv_q) begin
            ar_seen_addr = araddr;
            ar_seen_len  = arlen;
            ar_seen_size = arsize;
        end
        arv_q = arvalid;
    end

    task automatic model_reset();
        exp_arvalid = 1'b0;
        exp_rready  = 1'b0;
        exp_err     = 1'b0;
        exp_ok_cyc  = -1;
        for (int w = 0; w < NW; w++) exp_words[w] = '0;
    endtask

    // One request end to end. stop_after >= 0 applies reset before that beat.
    task automatic run_txn(input logic [31:0] a, input logic s, input logic [1:0] sz,
                           input int ar_delay, input int gap,
                           input logic [127:0] data, input logic [7:0] resp,
                           input logic [3:0] lastv, input bit hold, input int stop_after);
        int beats;
        @(negedge clk);
        req  = 1'b1;
        addr = a;
        suc  = s;
        size = sz;
        @(posedge clk); #1;
        last_t0    = cyc;
        beats      = s ? 1 : NW;
        exp_araddr = s ? a : {a[31:4], 4'b0};
        exp_arlen  = 8'(beats - 1);
        exp_arsize = s ? {1'b0, sz} : 3'd2;
        if (s) for (int w = 0; w < NW; w++) exp_words[w] = '0;
        exp_arvalid = 1'b1;
        exp_ok_cyc  = last_t0 + 1 + ar_delay + beats * (1 + gap);
        repeat (ar_delay) @(posedge clk);
        @(negedge clk);
        arready = 1'b1;
        @(posedge clk); #1;
        arready     = 1'b0;
        exp_arvalid = 1'b0;
        exp_rready  = 1'b1;
        for (int k = 0; k < beats; k++) begin
            if (k == stop_after) begin
                @(negedge clk);
                rst = 1'b1;
                req = 1'b0;
                @(posedge clk); #1;
                model_reset();
                @(negedge clk);
                rst    = 1'b0;
                rvalid = 1'b1;          // stray beat after reset must be ignored
                rdata  = 32'hDEAD_BEEF;
                rlast  = 1'b1;
                @(posedge clk); #1;
                rvalid = 1'b0;
                rlast  = 1'b0;
                return;
            end
            repeat (gap) @(posedge clk);
            @(negedge clk);
            rvalid = 1'b1;
            rdata  = data[32*k +: 32];
            rresp  = resp[2*k +: 2];
            rlast  = lastv[k];
            @(posedge clk); #1;
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            exp_words[k % beats] = data[32*k +: 32];
            if (resp[2*k +: 2] != 2'b00 || lastv[k] != (k == beats - 1)) exp_err = 1'b1;
            if (k == beats - 1) exp_rready = 1'b0;
        end
        @(negedge clk);
        if (!hold) req = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    int p0;

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; suc = 1'b0; size = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0; rvalid = 1'b0;
        arv_q = 1'b0; ok_pulses = 0; ok_seen_cyc = -1; last_t0 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Cached refill, zero wait.
        run_txn(32'h1C00_0024, 1'b0, 2'd2, 0, 0,
                {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h00, 4'b1000, 1'b0, -1);
        check("t1_din", din, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        check("t1_araddr", ar_seen_addr, 32'h1C00_0020);
        check("t1_arlen", ar_seen_len, 8'd3);
        check("t1_latency", ok_seen_cyc - last_t0, 5);
        check("t1_err", bus_err, 1'b0);

        // Uncached single-word fetch.
        run_txn(32'h1FD0_0004, 1'b1, 2'd2, 0, 0,
                {96'h0, 32'h1234_5678}, 8'h00, 4'b0001, 1'b0, -1);
        check("t2_din", din, {96'h0, 32'h1234_5678});
        check("t2_araddr", ar_seen_addr, 32'h1FD0_0004);
        check("t2_arlen", ar_seen_len, 8'd0);
        check("t2_arsize", ar_seen_size, 3'd2);
        check("t2_latency", ok_seen_cyc - last_t0, 2);

        // Delayed arready, gapped beats.
        p0 = ok_pulses;
        run_txn(32'h8000_001C, 1'b0, 2'd0, 3, 1,
                {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                8'h00, 4'b1000, 1'b0, -1);
        check("t3_din", din, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        check("t3_pulses", ok_pulses - p0, 1);
        check("t3_latency", ok_seen_cyc - last_t0, 1 + 3 + 4 * 2);

        // SLVERR and early rlast on beat index 2.
        p0 = ok_pulses;
        run_txn(32'h0000_1000, 1'b0, 2'd0, 0, 0,
                {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 8'b0010_0000, 4'b0100, 1'b0, -1);
        check("t4_err", bus_err, 1'b1);
        check("t4_pulses", ok_pulses - p0, 1);
        check("t4_din", din, {32'hD3, 32'hD2, 32'hD1, 32'hD0});

        // Request held across dataOK: second request starts only from IDLE.
        run_txn(32'h2000_0040, 1'b0, 2'd0, 0, 0,
                {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 8'h00, 4'b1000, 1'b1, -1);
        p0 = ok_seen_cyc;
        run_txn(32'h2000_0102, 1'b1, 2'd1, 0, 0,
                {96'h0, 32'hCAFE_F00D}, 8'h00, 4'b0001, 1'b0, -1);
        check("t5_restart", last_t0 - p0, 2);
        check("t5_din", din, {96'h0, 32'hCAFE_F00D});
        check("t5_arsize", ar_seen_size, 3'd1);
        check("t5_err_sticky", bus_err, 1'b1);

        // Reset after two beats, then a fresh refill.
        run_txn(32'h3000_0000, 1'b0, 2'd0, 0, 0,
                {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 8'h00, 4'b1000, 1'b0, 2);
        check("t6_err_clear", bus_err, 1'b0);
        check("t6_din_clear", din, 128'h0);
        run_txn(32'h3000_0030, 1'b0, 2'd0, 0, 0,
                {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 8'h00, 4'b1000, 1'b0, -1);
        check("t7_araddr", ar_seen_addr, 32'h3000_0030);
        check("t7_din", din, {32'hF3, 32'hF2, 32'hF1, 32'hF0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
